// File: rtl/gray_stream_monitor_if.sv
// Status bundle between the upstream Gray counter, the stream monitor and its observers.
// Plain level signals: no handshake, the monitor samples gray_in on every clock.
interface gray_stream_monitor_if #(
   parameter int CBITS  = 11,
   parameter int WRAP_W = 16
);
   logic [CBITS-1:0]  gray_in;
   logic              en;
   logic              clr_err;
   logic [CBITS-1:0]  bin_out;
   logic              bin_valid;
   logic              wrap_pulse;
   logic [WRAP_W-1:0] wrap_cnt;
   logic              step_err;
   logic              err_sticky;
   logic [7:0]        err_cnt;
   logic [1:0]        state;

   modport master (
      output gray_in, en, clr_err,
      input  bin_out, bin_valid, wrap_pulse, wrap_cnt, step_err, err_sticky, err_cnt, state
   );

   modport slave (
      input  gray_in, en, clr_err,
      output bin_out, bin_valid, wrap_pulse, wrap_cnt, step_err, err_sticky, err_cnt, state
   );
endinterface

// File: rtl/gray_stream_monitor.sv
// Resynchronises a free-running Gray count, decodes it to binary and flags every step that is not +1.
// Latency gray_in -> bin_out is SYNC_STAGES+1 cycles; no backpressure, the input is sampled every cycle.
module gray_stream_monitor #(
   parameter int CBITS       = 11,
   parameter int SYNC_STAGES = 2,
   parameter int WRAP_W      = 16
) (
   input logic                  clk,
   input logic                  rst,
   gray_stream_monitor_if.slave mon
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      TRACK = 2'd2,
      ERR   = 2'd3
   } state_t;

   localparam int            FW        = $clog2(SYNC_STAGES + 2);
   localparam logic [FW-1:0] FILL_LOAD = FW'(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0][CBITS-1:0] r_sync;
   logic [CBITS-1:0]                  w_gray;
   logic [CBITS-1:0]                  w_bin;
   logic [CBITS-1:0]                  w_delta;
   logic                              w_step_ok;
   logic                              w_step_bad;

   state_t            r_state;
   logic [FW-1:0]     r_fill;
   logic [CBITS-1:0]  r_bin;
   logic              r_bin_valid;
   logic              r_wrap_pulse;
   logic [WRAP_W-1:0] r_wrap_cnt;
   logic              r_step_err;
   logic              r_err_sticky;
   logic [7:0]        r_err_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], mon.gray_in};
      end
   end

   assign w_gray = r_sync[SYNC_STAGES-1];

   // Each binary bit is the XOR of all Gray bits at and above it.
   always_comb begin
      w_bin = '0;
      for (int i = 0; i < CBITS; i++) begin
         w_bin[i] = ^(w_gray >> i);
      end
   end

   assign w_delta    = w_bin - r_bin;
   assign w_step_ok  = (w_delta == CBITS'(1));
   assign w_step_bad = (w_delta != '0) && !w_step_ok;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_fill       <= '0;
         r_bin        <= '0;
         r_bin_valid  <= 1'b0;
         r_wrap_pulse <= 1'b0;
         r_wrap_cnt   <= '0;
         r_step_err   <= 1'b0;
         r_err_sticky <= 1'b0;
         r_err_cnt    <= '0;
      end else begin
         r_wrap_pulse <= 1'b0;
         r_step_err   <= 1'b0;

         if (r_state != IDLE) begin
            r_bin <= w_bin;
         end

         if (mon.clr_err) begin
            r_err_sticky <= 1'b0;
            r_err_cnt    <= '0;
         end

         case (r_state)
            IDLE: begin
               r_bin_valid <= 1'b0;
               if (mon.en) begin
                  r_state <= FILL;
                  r_fill  <= FILL_LOAD;
               end
            end

            // Stay here until the synchroniser and bin_out hold real samples.
            FILL: begin
               if (!mon.en) begin
                  r_state <= IDLE;
               end else begin
                  r_fill <= r_fill - 1'b1;
                  if (r_fill == FW'(1)) begin
                     r_state     <= TRACK;
                     r_bin_valid <= 1'b1;
                  end
               end
            end

            TRACK, ERR: begin
               if (!mon.en) begin
                  r_state     <= IDLE;
                  r_bin_valid <= 1'b0;
               end else if (w_step_bad) begin
                  // An illegal step overrides a coincident clear: the count restarts at 1.
                  r_step_err   <= 1'b1;
                  r_err_sticky <= 1'b1;
                  r_state      <= ERR;
                  if (mon.clr_err) begin
                     r_err_cnt <= 8'd1;
                  end else if (r_err_cnt != 8'hFF) begin
                     r_err_cnt <= r_err_cnt + 8'd1;
                  end
               end else begin
                  if (w_step_ok && (w_bin == '0)) begin
                     r_wrap_pulse <= 1'b1;
                     if (r_wrap_cnt != '1) begin
                        r_wrap_cnt <= r_wrap_cnt + 1'b1;
                     end
                  end
                  if ((r_state == ERR) && mon.clr_err) begin
                     r_state <= TRACK;
                  end
               end
            end

            default: r_state <= IDLE;
         endcase
      end
   end

   assign mon.bin_out    = r_bin;
   assign mon.bin_valid  = r_bin_valid;
   assign mon.wrap_pulse = r_wrap_pulse;
   assign mon.wrap_cnt   = r_wrap_cnt;
   assign mon.step_err   = r_step_err;
   assign mon.err_sticky = r_err_sticky;
   assign mon.err_cnt    = r_err_cnt;
   assign mon.state      = r_state;
endmodule

// File: tb/tb_gray_stream_monitor.sv
// Directed bench for gray_stream_monitor: counting, wraps, skips, clear collisions, saturation, reset.
// A 3-deep history of driven binary values gives the expected bin_out.
module tb_gray_stream_monitor;
   logic clk = 1'b0;
   logic rst;

   gray_stream_monitor_if #(.CBITS(11), .WRAP_W(16)) mon ();

   gray_stream_monitor #(
      .CBITS      (11),
      .SYNC_STAGES(2),
      .WRAP_W     (16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .mon(mon)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [10:0] u;
   logic [10:0] h0, h1, h2;
   logic [10:0] exp_bin;
   logic [10:0] hold;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   // Advance one clock, then drive the next upstream value; exp_bin is what bin_out must now show.
   task automatic cyc(input logic [10:0] nv);
      @(posedge clk);
      #1;
      exp_bin = h2;
      h2 = h1;
      h1 = h0;
      h0 = nv;
      u  = nv;
      mon.gray_in = nv ^ (nv >> 1);
   endtask

   task automatic count_run(input int n, output int wraps, output int bad, output int errs);
      wraps = 0;
      bad   = 0;
      errs  = 0;
      for (int i = 0; i < n; i++) begin
         cyc(u + 11'd1);
         if (mon.bin_out !== exp_bin || mon.bin_valid !== 1'b1) bad++;
         if (mon.wrap_pulse === 1'b1) begin
            wraps++;
            if (exp_bin != 11'd0) bad++;
         end
         if (mon.step_err === 1'b1) errs++;
      end
   endtask

   initial begin
      int w, b, e, ev, at3;
      rst = 1'b0;
      mon.en = 1'b0;
      mon.clr_err = 1'b0;
      mon.gray_in = '0;
      u = '0; h0 = '0; h1 = '0; h2 = '0; exp_bin = '0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_state", 32'(mon.state), 0);
      check("rst_bin", 32'(mon.bin_out), 0);
      check("rst_flags", 32'({mon.bin_valid, mon.wrap_pulse, mon.step_err, mon.err_sticky}), 0);
      check("rst_counts", 32'({mon.wrap_cnt, mon.err_cnt}), 0);
      rst = 1'b1;

      ev = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(11'd7);
         if (mon.bin_valid || mon.wrap_pulse || mon.step_err) ev++;
      end
      check("idle_state", 32'(mon.state), 0);
      check("idle_bin_hold", 32'(mon.bin_out), 0);
      check("idle_events", ev, 0);

      cyc(11'd0);
      mon.en = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         cyc(11'(i));
         check("fill_state", 32'(mon.state), 1);
      end
      check("fill_valid", 32'(mon.bin_valid), 0);
      cyc(11'd4);
      check("track_state", 32'(mon.state), 2);
      check("track_valid", 32'(mon.bin_valid), 1);
      check("track_first_bin", 32'(mon.bin_out), 1);

      count_run(2047, w, b, e);
      check("wrap1_pulses", w, 1);
      check("wrap1_pulse_now", 32'(mon.wrap_pulse), 1);
      check("wrap1_bin_zero", 32'(mon.bin_out), 0);
      check("wrap1_cnt", 32'(mon.wrap_cnt), 1);
      check("run1_bad", b, 0);
      check("run1_step_err", e, 0);

      count_run(2048, w, b, e);
      check("wrap2_pulses", w, 1);
      check("wrap2_cnt", 32'(mon.wrap_cnt), 2);
      check("run2_bad", b + e, 0);

      #2 rst = 1'b0;
      #1;
      check("arst_state", 32'(mon.state), 0);
      check("arst_bin", 32'(mon.bin_out), 0);
      check("arst_valid", 32'(mon.bin_valid), 0);
      check("arst_wrap_cnt", 32'(mon.wrap_cnt), 0);
      cyc(u + 11'd1);
      cyc(u + 11'd1);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(u + 11'd1);
         check("refill_state", 32'(mon.state), 1);
      end
      cyc(u + 11'd1);
      check("retrack_state", 32'(mon.state), 2);
      check("retrack_bin", 32'(mon.bin_out), 32'(exp_bin));

      count_run(3 * 2048, w, b, e);
      check("wrap3_pulses", w, 3);
      check("wrap3_cnt", 32'(mon.wrap_cnt), 3);
      check("run3_bad", b + e, 0);

      mon.en = 1'b0;
      cyc(11'd5);
      hold = exp_bin;
      check("dis_state", 32'(mon.state), 0);
      check("dis_valid", 32'(mon.bin_valid), 0);
      repeat (5) cyc(11'd5);
      check("dis_bin_hold", 32'(mon.bin_out), 32'(hold));
      check("dis_wrap_hold", 32'(mon.wrap_cnt), 3);

      mon.en = 1'b1;
      repeat (3) cyc(11'd5);
      cyc(11'd5);
      check("reen_state", 32'(mon.state), 2);
      check("reen_bin", 32'(mon.bin_out), 5);

      ev = 0; b = 0; at3 = 0;
      for (int i = 0; i < 15; i++) begin
         cyc(11'(9 + i));
         if (mon.bin_out !== exp_bin) b++;
         if (mon.step_err === 1'b1) begin
            ev++;
            if (i == 3) at3 = 1;
         end
      end
      check("skip_pulses", ev, 1);
      check("skip_pulse_timing", at3, 1);
      check("skip_err_cnt", 32'(mon.err_cnt), 1);
      check("skip_sticky", 32'(mon.err_sticky), 1);
      check("skip_state", 32'(mon.state), 3);
      check("skip_bin_bad", b, 0);

      cyc(11'd100);
      cyc(11'd101);
      cyc(11'd102);
      mon.clr_err = 1'b1;
      cyc(11'd103);
      mon.clr_err = 1'b0;
      check("coll_step_err", 32'(mon.step_err), 1);
      check("coll_err_cnt", 32'(mon.err_cnt), 1);
      check("coll_sticky", 32'(mon.err_sticky), 1);
      check("coll_state", 32'(mon.state), 3);

      ev = 0;
      for (int i = 0; i < 7; i++) begin
         cyc(11'(104 + i));
         if (mon.step_err === 1'b1) ev++;
      end
      check("post_coll_events", ev, 0);
      mon.clr_err = 1'b1;
      cyc(11'd111);
      mon.clr_err = 1'b0;
      check("clr_err_cnt", 32'(mon.err_cnt), 0);
      check("clr_sticky", 32'(mon.err_sticky), 0);
      check("clr_state", 32'(mon.state), 2);

      ev = 0;
      for (int i = 0; i < 300; i++) begin
         cyc(u + 11'd2);
         if (mon.step_err === 1'b1) ev++;
      end
      for (int i = 0; i < 10; i++) begin
         cyc(u);
         if (mon.step_err === 1'b1) ev++;
      end
      check("sat_pulses", ev, 300);
      check("sat_err_cnt", 32'(mon.err_cnt), 255);
      check("sat_sticky", 32'(mon.err_sticky), 1);
      check("sat_state", 32'(mon.state), 3);
      check("sat_wrap_hold", 32'(mon.wrap_cnt), 3);

      mon.en = 1'b0;
      cyc(u);
      cyc(u);
      check("err_dis_state", 32'(mon.state), 0);
      check("err_dis_cnt_hold", 32'(mon.err_cnt), 255);
      mon.clr_err = 1'b1;
      cyc(u);
      mon.clr_err = 1'b0;
      check("idle_clr_cnt", 32'(mon.err_cnt), 0);
      check("idle_clr_sticky", 32'(mon.err_sticky), 0);
      check("idle_clr_state", 32'(mon.state), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
